alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_pkg.sv | 37 +++
 rtl/alu_sequencer_if.sv | 32 +++
 rtl/alu_sequencer_seq_mem_port.sv | 53 +++++
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU sequencer
// and the ALU it drives.
package alu_sequencer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OPC_W  = 4;

   // ALU codes match the ALU's own encoding
   localparam logic [OPC_W-1:0] OPC_ADD = 4'b0000;
   localparam logic [OPC_W-1:0] OPC_SUB = 4'b0001;
   localparam logic [OPC_W-1:0] OPC_AND = 4'b0010;
   localparam logic [OPC_W-1:0] OPC_NOT = 4'b0011;
   localparam logic [OPC_W-1:0] OPC_OR  = 4'b0100;
   localparam logic [OPC_W-1:0] OPC_MUL = 4'b0101;
   localparam logic [OPC_W-1:0] OPC_LDA = 4'b1000;
   localparam logic [OPC_W-1:0] OPC_STA = 4'b1001;
   localparam logic [OPC_W-1:0] OPC_JMP = 4'b1010;
   localparam logic [OPC_W-1:0] OPC_JZ  = 4'b1011;
   localparam logic [OPC_W-1:0] OPC_JO  = 4'b1100;
   localparam logic [OPC_W-1:0] OPC_HLT = 4'b1111;

   typedef enum logic [2:0] {
      ST_FETCH0,
      ST_FETCH1,
      ST_READ_OP,
      ST_EXEC,
      ST_WRITE,
      ST_HALT
   } state_e;

   // Instructions that carry an address/target byte after the opcode
   function automatic logic has_byte1(input logic [OPC_W-1:0] opc);
      return opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_MUL,
                         OPC_LDA, OPC_STA, OPC_JMP, OPC_JZ, OPC_JO};
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Memory handshake plus ALU operand/result bundle between the sequencer
// (master) and its environment (slave: memory and combinational ALU).
interface alu_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   import alu_sequencer_pkg::*;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic [OPC_W-1:0]  op;
   logic [DATA_W-1:0] reg_y;
   logic [DATA_W-1:0] bus1;
   logic [DATA_W-1:0] alu_out;
   logic              alu_0_flag;
   logic              alu_o_flag;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_wdata, op, reg_y, bus1,
      input  mem_rdata, mem_ready, alu_out, alu_0_flag, alu_o_flag
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_wdata, op, reg_y, bus1,
      output mem_rdata, mem_ready, alu_out, alu_0_flag, alu_o_flag
   );

endinterface

// File: rtl/alu_sequencer_seq_mem_port.sv
// Registered memory request port: holds rd/wr/addr/wdata stable until
// mem_ready completes the outstanding request.
module seq_mem_port
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_rd_i,
   input  logic              req_wr_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic              mem_ready_i,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              done_c_o
);

   logic              rd_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              busy_c;
   logic              load_c;

   assign busy_c   = rd_q | wr_q;
   assign done_c_o = busy_c & mem_ready_i;
   assign load_c   = ~busy_c | mem_ready_i;

   // A new request is only taken once the previous one has completed
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (load_c) begin
         rd_q    <= req_rd_i;
         wr_q    <= req_wr_i & ~req_rd_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
      end
   end

   assign mem_rd_o    = rd_q;
   assign mem_wr_o    = wr_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU: fetches over a byte-wide memory
// handshake, owns ACC/Y/operand latch, and resolves jumps on latched flags.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_sequencer_if.master       bus,
   output logic [DATA_W-1:0]     acc,
   output logic                  z_flag,
   output logic                  o_flag,
   output logic                  halted
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OPC_W-1:0]  ir_q, ir_d;
   logic [OPC_W-1:0]  op_q, op_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] reg_y_q, reg_y_d;
   logic [DATA_W-1:0] bus1_q, bus1_d;
   logic              z_q, z_d;
   logic              o_q, o_d;
   logic              halted_q;

   logic              done_c;
   logic [OPC_W-1:0]  opc_c;
   logic              req_rd_c;
   logic              req_wr_c;
   logic [ADDR_W-1:0] req_addr_c;

   assign opc_c = bus.mem_rdata[DATA_W-1:DATA_W-OPC_W];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      op_d    = op_q;
      acc_d   = acc_q;
      reg_y_d = reg_y_q;
      bus1_d  = bus1_q;
      z_d     = z_q;
      o_d     = o_q;
      case (state_q)
         ST_FETCH0: if (done_c) begin
            ir_d = opc_c;
            pc_d = pc_q + ADDR_W'(1);
            if (opc_c == OPC_NOT) begin
               reg_y_d = acc_q;
               op_d    = OPC_NOT;
               state_d = ST_EXEC;
            end else if (opc_c == OPC_HLT) begin
               state_d = ST_HALT;
            end else if (has_byte1(opc_c)) begin
               state_d = ST_FETCH1;
            end
         end
         ST_FETCH1: if (done_c) begin
            addr_d  = ADDR_W'(bus.mem_rdata);
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_READ_OP;
            case (ir_q)
               OPC_JMP: begin pc_d = ADDR_W'(bus.mem_rdata); state_d = ST_FETCH0; end
               OPC_JZ:  begin if (z_q) pc_d = ADDR_W'(bus.mem_rdata); state_d = ST_FETCH0; end
               OPC_JO:  begin if (o_q) pc_d = ADDR_W'(bus.mem_rdata); state_d = ST_FETCH0; end
               OPC_STA: state_d = ST_WRITE;
               default: ;
            endcase
         end
         ST_READ_OP: if (done_c) begin
            bus1_d  = bus.mem_rdata;
            reg_y_d = acc_q;
            if (ir_q == OPC_LDA) begin
               acc_d   = bus.mem_rdata;
               state_d = ST_FETCH0;
            end else begin
               op_d    = ir_q;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            acc_d   = bus.alu_out;
            z_d     = bus.alu_0_flag;
            o_d     = bus.alu_o_flag;
            state_d = ST_FETCH0;
         end
         ST_WRITE: if (done_c) state_d = ST_FETCH0;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_FETCH0;
      endcase
   end

   // Request for the state being entered, so it is on the bus in that state's first cycle
   assign req_rd_c   = state_d inside {ST_FETCH0, ST_FETCH1, ST_READ_OP};
   assign req_wr_c   = (state_d == ST_WRITE);
   assign req_addr_c = (state_d inside {ST_READ_OP, ST_WRITE}) ? addr_d : pc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH0;
         pc_q     <= RESET_PC;
         addr_q   <= '0;
         ir_q     <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         reg_y_q  <= '0;
         bus1_q   <= '0;
         z_q      <= 1'b0;
         o_q      <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         ir_q     <= ir_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         reg_y_q  <= reg_y_d;
         bus1_q   <= bus1_d;
         z_q      <= z_d;
         o_q      <= o_d;
         halted_q <= (state_d == ST_HALT);
      end
   end

   seq_mem_port #(.ADDR_W(ADDR_W)) u_mem_port (
      .clk         (clk),
      .rst         (rst),
      .req_rd_i    (req_rd_c),
      .req_wr_i    (req_wr_c),
      .req_addr_i  (req_addr_c),
      .req_wdata_i (acc_d),
      .mem_ready_i (bus.mem_ready),
      .mem_rd_o    (bus.mem_rd),
      .mem_wr_o    (bus.mem_wr),
      .mem_addr_o  (bus.mem_addr),
      .mem_wdata_o (bus.mem_wdata),
      .done_c_o    (done_c)
   );

   assign bus.op    = op_q;
   assign bus.reg_y = reg_y_q;
   assign bus.bus1  = bus1_q;
   assign acc       = acc_q;
   assign z_flag    = z_q;
   assign o_flag    = o_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memory + ALU environment, an instruction-level
// reference model feeding an expected-transaction queue, and a bus monitor.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int unsigned ADDR_W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] acc;
   logic       z_flag, o_flag, halted;

   alu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   alu_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus.master),
      .acc    (acc),
      .z_flag (z_flag),
      .o_flag (o_flag),
      .halted (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wd;
      logic [7:0] acc;
      logic       z;
      logic       o;
   } txn_t;

   txn_t       exp_q[$];
   logic [7:0] prog [256];
   logic [7:0] mem  [256];
   int         fs   [256];
   int         ready_mode = 1;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc_cnt = 0;
   logic [7:0] m_acc;
   logic       m_z, m_o;
   bit         m_halt;

   // Combinational ALU: {o, z, result}; operand A = reg_y, operand B = bus1
   function automatic logic [9:0] alu_env(input logic [3:0] opc, input logic [7:0] a,
                                          input logic [7:0] b);
      logic [15:0] p;
      logic [7:0]  r;
      logic        ov;
      p  = 16'(a) * 16'(b);
      ov = 1'b0;
      case (opc)
         OPC_ADD: begin r = a + b; ov = (9'(a) + 9'(b)) > 9'd255; end
         OPC_SUB: begin r = a - b; ov = (a < b); end
         OPC_AND: r = a & b;
         OPC_NOT: r = ~a;
         OPC_OR:  r = a | b;
         OPC_MUL: begin r = p[7:0]; ov = (p > 16'd255); end
         default: r = 8'h00;
      endcase
      return {ov, (r == 8'h00), r};
   endfunction

   assign {bus.alu_o_flag, bus.alu_0_flag, bus.alu_out} = alu_env(bus.op, bus.reg_y, bus.bus1);

   // Memory responder: image reload while in reset, writes on completion
   initial begin : responder
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) mem = prog;
         else if (bus.mem_wr && bus.mem_ready) mem[bus.mem_addr] = bus.mem_wdata;
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       bus.mem_ready = 1'b1;
            2:       bus.mem_ready = !bus.mem_wr;
            default: bus.mem_ready = ($urandom_range(0, 3) != 0);
         endcase
         bus.mem_rdata = mem[bus.mem_addr];
      end
   end

   // Monitor: stall stability, rd/wr exclusivity, completed transactions vs scoreboard
   initial begin : monitor
      txn_t        e;
      logic [17:0] cur, prev_req;
      bit          prev_valid;
      prev_valid = 0;
      prev_req   = '0;
      forever begin
         @(negedge clk);
         cyc_cnt++;
         cur = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
         if (rst) begin
            prev_valid = 0;
            for (int i = 0; i < 256; i++) fs[i] = -1;
         end else begin
            if (prev_valid) begin
               n_cmp++;
               if (cur != prev_req) begin
                  n_fail++;
                  $display("FAIL stall_hold: got rd/wr/addr/wd=%h want %h", cur, prev_req);
               end
            end
            if (bus.mem_rd || bus.mem_wr) begin
               if (fs[bus.mem_addr] < 0) fs[bus.mem_addr] = cyc_cnt;
               n_cmp++;
               if (bus.mem_rd && bus.mem_wr) begin
                  n_fail++;
                  $display("FAIL rd_wr_excl: got rd=1 wr=1 want one of them");
               end
               if (bus.mem_ready && exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  n_cmp++;
                  if (bus.mem_wr != e.wr || bus.mem_addr != e.addr ||
                      (e.wr && bus.mem_wdata != e.wd) || acc != e.acc ||
                      z_flag != e.z || o_flag != e.o) begin
                     n_fail++;
                     $display("FAIL txn: got wr=%b addr=%h wd=%h acc=%h z=%b o=%b want wr=%b addr=%h wd=%h acc=%h z=%b o=%b",
                              bus.mem_wr, bus.mem_addr, bus.mem_wdata, acc, z_flag, o_flag,
                              e.wr, e.addr, e.wd, e.acc, e.z, e.o);
                  end
               end
            end
            prev_valid = (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
            prev_req   = cur;
         end
      end
   end

   task automatic push_txn(input logic wr, input logic [7:0] a, input logic [7:0] wd);
      txn_t t;
      t.wr = wr; t.addr = a; t.wd = wd; t.acc = m_acc; t.z = m_z; t.o = m_o;
      exp_q.push_back(t);
   endtask

   // Instruction-level interpreter: emits every bus transaction the program implies
   task automatic model_run(input int max_ins);
      logic [7:0]  m [256];
      logic [7:0]  pc, b1, d;
      logic [3:0]  opc;
      logic [15:0] prod;
      m = prog; pc = 8'h00; m_acc = 8'h00; m_z = 1'b0; m_o = 1'b0; m_halt = 0;
      for (int n = 0; n <= max_ins; n++) begin
         push_txn(1'b0, pc, 8'h00);
         if (n == max_ins) break;
         opc = m[pc][7:4];
         pc  = pc + 8'd1;
         if (opc == OPC_HLT) begin m_halt = 1; break; end
         if (opc == OPC_NOT) begin
            m_acc = ~m_acc; m_z = (m_acc == 8'h00); m_o = 1'b0;
            continue;
         end
         if (!(opc inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12})) continue;
         b1 = m[pc];
         push_txn(1'b0, pc, 8'h00);
         pc = pc + 8'd1;
         case (opc)
            OPC_JMP: pc = b1;
            OPC_JZ:  if (m_z) pc = b1;
            OPC_JO:  if (m_o) pc = b1;
            OPC_STA: begin push_txn(1'b1, b1, m_acc); m[b1] = m_acc; end
            OPC_LDA: begin push_txn(1'b0, b1, 8'h00); m_acc = m[b1]; end
            default: begin
               push_txn(1'b0, b1, 8'h00);
               d = m[b1];
               case (opc)
                  OPC_ADD: {m_o, m_acc} = 9'(m_acc) + 9'(d);
                  OPC_SUB: begin m_o = (m_acc < d); m_acc = m_acc - d; end
                  OPC_AND: begin m_o = 1'b0; m_acc = m_acc & d; end
                  OPC_OR:  begin m_o = 1'b0; m_acc = m_acc | d; end
                  default: begin prod = 16'(m_acc) * 16'(d); m_acc = prod[7:0]; m_o = (prod[15:8] != 0); end
               endcase
               m_z = (m_acc == 8'h00);
            end
         endcase
      end
   endtask

   task automatic run_prog(input string name, input int max_ins);
      int c;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_run(max_ins);
      rst = 1'b0;
      c = 0;
      while (exp_q.size() != 0 && c < 4000) begin @(negedge clk); c++; end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: got %0d transactions outstanding want 0", name, exp_q.size());
         exp_q.delete();
      end
      if (m_halt) begin
         repeat (3) @(negedge clk);
         n_cmp++;
         if (!halted || acc != m_acc || z_flag != m_z || o_flag != m_o) begin
            n_fail++;
            $display("FAIL %s final: got halted=%b acc=%h z=%b o=%b want halted=1 acc=%h z=%b o=%b",
                     name, halted, acc, z_flag, o_flag, m_acc, m_z, m_o);
         end
      end
   endtask

   task automatic chk_lat(input string name, input int a, input int b, input int want);
      n_cmp++;
      if (fs[a] < 0 || fs[b] < 0 || fs[b] - fs[a] != want) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, fs[b] - fs[a], want);
      end
   endtask

   task automatic check_reset(input string name);
      logic [49:0] v;
      v = {acc, z_flag, o_flag, halted, bus.mem_rd, bus.mem_wr, bus.mem_addr,
           bus.mem_wdata, bus.op, bus.reg_y, bus.bus1};
      n_cmp++;
      if (v != '0) begin
         n_fail++;
         $display("FAIL %s reset_vals: got %h want 0", name, v);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 8'hF0;
   endtask

   task automatic load_p1();
      clear_prog();
      prog[0] = 8'h80; prog[1] = 8'h20; prog[2] = 8'h00; prog[3] = 8'h21;
      prog[4] = 8'h90; prog[5] = 8'h22; prog[8'h20] = 8'h05; prog[8'h21] = 8'h03;
   endtask

   initial begin : stimulus
      int c;
      int hits;
      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      ready_mode = 1;
      repeat (2) @(negedge clk);
      check_reset("power_on");

      // LDA/ADD/STA, ready tied high
      load_p1();
      run_prog("p1", 20);
      chk_lat("p1", 0, 6, 10);
      n_cmp++;
      if (mem[8'h22] != 8'h08) begin
         n_fail++;
         $display("FAIL p1 store: got %h want 08", mem[8'h22]);
      end
      hits = 0;
      repeat (20) begin @(negedge clk); if (bus.mem_rd || bus.mem_wr) hits++; end
      n_cmp++;
      if (hits != 0 || !halted) begin
         n_fail++;
         $display("FAIL halt_quiet: got %0d request cycles halted=%b want 0 and 1", hits, halted);
      end

      // Carry to zero then JZ taken; second JZ with z clear falls through
      clear_prog();
      prog[0] = 8'h80; prog[1] = 8'h30; prog[2] = 8'h00; prog[3] = 8'h31;
      prog[4] = 8'hB0; prog[5] = 8'h40;
      prog[8'h40] = 8'h80; prog[8'h41] = 8'h32; prog[8'h42] = 8'h00; prog[8'h43] = 8'h32;
      prog[8'h44] = 8'hB0; prog[8'h45] = 8'h60;
      prog[8'h30] = 8'hFF; prog[8'h31] = 8'h01; prog[8'h32] = 8'h01;
      run_prog("jz", 20);
      chk_lat("jz", 4, 8'h40, 2);

      // SUB with borrow then NOT
      clear_prog();
      prog[0] = 8'h80; prog[1] = 8'h20; prog[2] = 8'h10; prog[3] = 8'h21;
      prog[4] = 8'h30; prog[5] = 8'hF0; prog[8'h20] = 8'h03; prog[8'h21] = 8'h05;
      run_prog("sub_not", 20);
      chk_lat("sub", 2, 4, 4);
      chk_lat("not", 4, 5, 2);

      // JMP to 0xFF: LDA whose address byte wraps to 0x00
      clear_prog();
      prog[0] = 8'hA0; prog[1] = 8'hFF; prog[8'hFF] = 8'h80; prog[8'hA0] = 8'h5A;
      run_prog("wrap", 20);

      // Same first program with random stalls
      ready_mode = 0;
      load_p1();
      run_prog("p1_stall", 20);

      // Reset while a write is stalled
      ready_mode = 2;
      clear_prog();
      prog[0] = 8'h80; prog[1] = 8'h20; prog[2] = 8'h90; prog[3] = 8'h50;
      prog[8'h20] = 8'h77;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      c = 0;
      while (!bus.mem_wr && c < 50) begin @(negedge clk); c++; end
      n_cmp++;
      if (!bus.mem_wr) begin
         n_fail++;
         $display("FAIL sta_stall: got mem_wr=0 want 1");
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid_sta");

      // Random memory images
      for (int k = 0; k < 30; k++) begin
         ready_mode = (k % 5 == 4) ? 1 : 0;
         for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
         run_prog("random", 60);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
